// File: rtl/nrisc_pkg.sv
// nRisc shared definitions: opcodes, fetch FSM encoding, immediate width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nrisc_pkg;

  // Width of the immediate / offset field at the bottom of every instruction
  localparam int IMM_W = 5;

  // Opcode map as seen by the control unit
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JUMP = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Fetch-stage sequencing
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/nrisc_pc_next.sv
// Next-PC selection: jump-in-page, pc-relative branch, or sequential increment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the result is committed.
module nrisc_pc_next
  import nrisc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [IMM_W-1:0] i_imm,
  input  logic             i_br_taken,
  input  logic             i_jmp_taken,
  output logic [PC_W-1:0]  o_pc_next
);

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_imm_sext;

  // Sequential address and sign-extended branch offset; both wrap modulo 2^PC_W
  assign w_pc_inc   = i_pc + PC_W'(1);
  assign w_imm_sext = {{(PC_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};

  // Jump beats branch; an undriven (x) taken flag falls through to the increment
  always_comb begin
    o_pc_next = w_pc_inc;
    if (i_jmp_taken) begin
      o_pc_next = {w_pc_inc[PC_W-1:IMM_W], i_imm};
    end else if (i_br_taken) begin
      o_pc_next = w_pc_inc + w_imm_sext;
    end
  end

endmodule

// File: rtl/nrisc_fetch_unit.sv
// nRisc fetch/PC stage: fetches into the IR, waits on control, computes next PC or halts. Optional macro NRISC_RESUME_EN adds a resume input.
// Latency: 4 cycles per instruction (FETCH, WAIT, DECODE, EXEC) plus one per extra WAIT cycle.
// Backpressure: stalls in WAIT indefinitely until imem_ready; no timeout.
module nrisc_fetch_unit
  import nrisc_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  output logic [2:0]         OPcode,
  output logic [INSTR_W-1:0] instr,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               EscPc,
  input  logic               zero,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef NRISC_RESUME_EN
  ,
  input  logic               resume
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               w_load_ir;
  logic               w_load_pc;
  logic               w_br_taken;
  logic               w_jmp_taken;
  logic [PC_W-1:0]    w_pc_next;

  // Control outputs only matter in EXEC; anything other than a clean 1 is not-taken
  assign w_jmp_taken = (r_state == ST_EXEC) && (Jump == 1'b1);
  assign w_br_taken  = (r_state == ST_EXEC) && (Branch == 1'b1) && (zero == 1'b1);

  nrisc_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .i_pc        (r_pc),
    .i_imm       (r_ir[IMM_W-1:0]),
    .i_br_taken  (w_br_taken),
    .i_jmp_taken (w_jmp_taken),
    .o_pc_next   (w_pc_next)
  );

  // State register; reset always restarts the fetch at FETCH
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath load enables
  always_comb begin
    w_state_nxt = r_state;
    w_load_ir   = 1'b0;
    w_load_pc   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ready) begin
          w_load_ir   = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        // EscPc must be a clean 1 to keep running; anything else halts with pc frozen
        if (EscPc == 1'b1) begin
          w_load_pc   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
`ifdef NRISC_RESUME_EN
        // Taken flags are gated off outside EXEC, so next pc is the plain increment
        if (resume) begin
          w_load_pc   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // PC and instruction register; reset abandons any pending fetch or update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (w_load_ir) begin
        r_ir <= imem_data;
      end
      if (w_load_pc) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign imem_rd   = (r_state == ST_FETCH) && !reset;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_ir;
  assign OPcode    = r_ir[INSTR_W-1 -: 3];
  assign halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_nrisc_fetch_unit.sv
// Directed bench for nrisc_fetch_unit with an instruction-level reference model.
// Latency: each instruction is stepped through its FETCH/WAIT/DECODE/EXEC cycles.
// Backpressure: WAIT stalls are injected by holding imem_ready low.
module tb_nrisc_fetch_unit;

  logic       clock;
  logic       reset;
  logic [7:0] imem_addr;
  logic       imem_rd;
  logic [7:0] imem_data;
  logic       imem_ready;
  logic [2:0] OPcode;
  logic [7:0] instr;
  logic       Branch;
  logic       Jump;
  logic       EscPc;
  logic       zero;
  logic [7:0] pc;
  logic       halted;
`ifdef NRISC_RESUME_EN
  logic       resume;
`endif

  nrisc_fetch_unit #(
    .PC_W    (8),
    .INSTR_W (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .OPcode     (OPcode),
    .instr      (instr),
    .Branch     (Branch),
    .Jump       (Jump),
    .EscPc      (EscPc),
    .zero       (zero),
    .pc         (pc),
    .halted     (halted)
`ifdef NRISC_RESUME_EN
    ,
    .resume     (resume)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: architectural view of what the outputs must be this cycle
  int m_pc;
  int m_ir;
  int m_halted;
  int m_rd;
  bit chk_en;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison on the falling edge
  always @(negedge clock) begin
    if (chk_en) begin
      chk("pc", int'(pc), m_pc);
      chk("imem_addr", int'(imem_addr), m_pc);
      chk("instr", int'(instr), m_ir);
      chk("OPcode", int'(OPcode), (m_ir >> 5) & 7);
      chk("halted", int'(halted), m_halted);
      chk("imem_rd", int'(imem_rd), m_rd);
    end
  end

  // Control inputs outside EXEC are driven to misleading values; they must be ignored
  task automatic idle_ctrl();
    EscPc  = 1'b0;
    Jump   = 1'b1;
    Branch = 1'b1;
    zero   = 1'b1;
  endtask

  // Entered just after the edge that starts FETCH; leaves just after the edge that ends EXEC
  task automatic run_instr(input logic [7:0] ins, input int nwait, input logic esc,
                           input logic jmp, input logic br, input logic z, input int exp_pc);
    int  pinc;
    int  imm;
    int  simm;
    int  nxt;
    bit  halt;
    // FETCH: ready and data are garbage here and must not reach the IR
    imem_data  = ~ins;
    imem_ready = 1'b1;
    @(posedge clock); #1;
    // WAIT
    m_rd       = 0;
    imem_data  = ins;
    imem_ready = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      @(posedge clock); #1;
    end
    imem_ready = 1'b1;
    @(posedge clock); #1;
    // DECODE
    m_ir       = int'(ins);
    imem_ready = 1'b0;
    imem_data  = ~ins;
    chk("opcode_at_decode", int'(OPcode), int'(ins[7:5]));
    @(posedge clock); #1;
    // EXEC
    EscPc  = esc;
    Jump   = jmp;
    Branch = br;
    zero   = z;
    pinc = (m_pc + 1) % 256;
    imm  = int'(ins[4:0]);
    simm = (imm >= 16) ? imm - 32 : imm;
    halt = 1'b0;
    if (esc !== 1'b1) begin
      nxt  = m_pc;
      halt = 1'b1;
    end else if (jmp === 1'b1) begin
      nxt = (pinc / 32) * 32 + imm;
    end else if (br === 1'b1 && z === 1'b1) begin
      nxt = (pinc + simm + 256) % 256;
    end else begin
      nxt = pinc;
    end
    chk("model_next_pc", nxt, exp_pc);
    @(posedge clock); #1;
    idle_ctrl();
    imem_ready = 1'b1;
    m_pc = nxt;
    if (halt) begin
      m_halted = 1;
      m_rd     = 0;
    end else begin
      m_rd = 1;
    end
    chk("pc_after_exec", int'(pc), exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    m_pc = 0; m_ir = 0; m_halted = 0; m_rd = 0;
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_data = 8'h00;
    idle_ctrl();
`ifdef NRISC_RESUME_EN
    resume = 1'b0;
`endif
    @(posedge clock); #1;
    chk_en = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_rd  = 1;

    // Sequential flow, stalls, branch taken/not-taken, jump priority
    run_instr(8'b000_00001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run_instr(8'b000_00010, 3, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    run_instr(8'b010_00011, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    run_instr(8'b011_00100, 1, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    run_instr(8'b101_00000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    run_instr(8'b011_11101, 0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    run_instr(8'b100_00101, 2, 1'b1, 1'b1, 1'b1, 1'b1, 5);
    run_instr(8'b011_11101, 0, 1'b1, 1'b0, 1'b1, 1'b0, 6);
    run_instr(8'b110_00000, 0, 1'b1, 1'bx, 1'bx, 1'b1, 7);

    // Reset during WAIT with a late ready: fetch abandoned, IR not loaded
    imem_data  = 8'hAB;
    imem_ready = 1'b0;
    @(posedge clock); #1;
    m_rd       = 0;
    reset      = 1'b1;
    imem_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_pc = 0; m_ir = 0; m_rd = 1;
    chk("rst_wait_pc", int'(pc), 0);
    chk("rst_wait_ir", int'(instr), 0);

    // Wrap-around: backward branch from 0, jump from all-ones, forward branches
    run_instr(8'b011_11110, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    run_instr(8'b100_10010, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
    run_instr(8'b011_01110, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21);
    run_instr(8'b011_01111, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h31);
    run_instr(8'b011_01111, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41);
    run_instr(8'b100_10010, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h52);

    // Halt: everything frozen, no fetches, noise on memory ignored
    run_instr(8'b111_00000, 0, 1'b0, 1'bx, 1'bx, 1'b1, 8'h52);
    chk("halt_flag", int'(halted), 1);
    repeat (20) begin
      imem_data  = 8'($urandom);
      imem_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end

`ifdef NRISC_RESUME_EN
    resume = 1'b1;
    @(posedge clock); #1;
    resume = 1'b0;
    m_pc = (m_pc + 1) % 256; m_halted = 0; m_rd = 1;
    chk("resume_pc", int'(pc), 8'h53);
    run_instr(8'b000_00001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h54);
    run_instr(8'b111_00000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h54);
    repeat (3) begin
      @(posedge clock); #1;
    end
`endif

    // Reset out of HALTED, then one instruction from address 0
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_pc = 0; m_ir = 0; m_halted = 0; m_rd = 1;
    chk("halt_rst_halted", int'(halted), 0);
    chk("halt_rst_pc", int'(pc), 0);
    run_instr(8'b001_00111, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nrisc_fetch_unit.md
# nrisc_fetch_unit

Instruction fetch and program-counter stage of the nRisc core, directly upstream of the control unit. Fetches one 8-bit instruction per instruction cycle from instruction memory through a ready handshake and holds it in an instruction register. Presents the 3-bit opcode to the control unit, waits one cycle for the control unit's registered outputs, then uses its `Branch`, `Jump` and `EscPc` outputs to compute the next PC, or to halt.

## Interface
- `PC_W`, 8: PC and instruction-memory address width. Must be ≥ 6.
- `INSTR_W`, 8: instruction width. Opcode is `[INSTR_W-1:INSTR_W-3]`; the immediate field is `[4:0]`.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out PC_W: fetch address; equals `pc`.
- `imem_rd` out 1: read request; high only in FETCH.
- `imem_data` in INSTR_W: instruction word; sampled only in WAIT when `imem_ready` = 1.
- `imem_ready` in 1: memory data valid.
- `OPcode` out 3: `ir[INSTR_W-1:INSTR_W-3]`; drives the control unit.
- `instr` out INSTR_W: instruction register `ir`.
- `Branch` in 1: from the control unit.
- `Jump` in 1: from the control unit.
- `EscPc` in 1: from the control unit.
- `zero` in 1: ALU zero flag for beq; valid in EXEC.
- `pc` out PC_W: current program counter.
- `halted` out 1: high while in HALTED.

## Operation
- FSM states: FETCH, WAIT, DECODE, EXEC, HALTED. Reset state is FETCH.
- FETCH:
  - Assert `imem_rd`; `imem_addr` = `pc`.
  - Go to WAIT unconditionally.
- WAIT:
  - Hold `imem_rd` low.
  - On `imem_ready` = 1: load `ir` ← `imem_data` and go to DECODE.
  - Otherwise stay in WAIT, with no timeout.
- DECODE:
  - `OPcode` is stable.
  - The control unit registers its outputs on this cycle's closing edge.
  - Go to EXEC.
- EXEC (control outputs valid):
  - If `EscPc` ≠ 1: `pc` unchanged; go to HALTED.
  - Else if `Jump` = 1: `pc` ← `{pc_inc[PC_W-1:5], ir[4:0]}`.
  - Else if `Branch` = 1 and `zero` = 1: `pc` ← `pc_inc + sext(ir[4:0])`.
  - Else: `pc` ← `pc_inc`.
  - Go to FETCH in all three non-halt cases.
- Input value rule: any `Branch`/`Jump` value other than 1'b1 (including z/x, which the control unit drives on halt and jump) is treated as not-taken.
- Arithmetic: `pc_inc` = `pc + 1`. All PC arithmetic is modulo 2^PC_W, so `pc` = all-ones wraps to 0. The branch offset is a signed 5-bit value, range −16..+15.
- HALTED: `halted` = 1; `pc` and `ir` frozen; `imem_rd` = 0. Exit is by reset only (see Configuration).
- `imem_ready` outside WAIT is ignored.

## Timing
- Reset values: `pc` = 0, `ir` = 0, `OPcode` = 0, `instr` = 0, `imem_addr` = 0, `halted` = 0, `imem_rd` = 0 while `reset` is high.
- The first `imem_rd` pulse occurs in the first cycle after `reset` deasserts.
- Per instruction: 4 cycles minimum (FETCH, WAIT with same-cycle ready, DECODE, EXEC), plus one cycle per extra WAIT cycle.
- `imem_rd` is a one-cycle pulse per instruction.
- The new `pc` is visible in the cycle after EXEC, which is FETCH.
- Reset mid-WAIT or mid-EXEC: the pending fetch is abandoned, no `pc` update occurs, and the FSM restarts in FETCH at `pc` = 0.
- Reset while HALTED: leaves HALTED, `halted` = 0 the next cycle.

## Configuration
- `NRISC_RESUME_EN` defined:
  - Adds input port `resume` (1 bit).
  - In HALTED, `resume` = 1 sets `pc` ← `pc_inc`, clears `halted` and enters FETCH on the next cycle.
  - `resume` outside HALTED is ignored.
- Undefined: no `resume` port; HALTED is exited only by `reset`.

## Structure
- Shared package `nrisc_pkg`:
  - Opcode constants OP_ADD = 000, OP_MOVE = 001, OP_SLT = 010, OP_BEQ = 011, OP_JUMP = 100, OP_SW = 101, OP_LW = 110, OP_HALT = 111.
  - FSM state encoding.
  - Immediate field width (5).
- One sub-module, `nrisc_pc_next`: purely combinational; inputs `pc`, `ir[4:0]`, taken-branch, taken-jump; output next `pc`.

## Test plan
- Reset release with `imem_ready` tied high, mem[0] = 8'b000_00001 (add) → `imem_rd` pulses at cycle 1; `OPcode` = 000 at DECODE; `pc` = 1 after 4 cycles.
- `imem_ready` held low 3 extra cycles on mem[1] → `ir` is loaded only on the ready cycle; `pc` advances to 2 after 7 cycles; `imem_rd` pulses only once.
- beq at `pc` = 5 with `ir[4:0]` = 5'b11101 (−3): `zero` = 1 → `pc` = 3; `zero` = 0 → `pc` = 6.
- Jump at `pc` = 8'h41 with `ir[4:0]` = 5'h12 → `pc` = 8'h52. A jump at `pc` = 8'hFF computes from `pc_inc` = 0, giving `pc` = 8'h12.
- Halt opcode 111 with `EscPc` = 0 → `halted` = 1, `pc` frozen, no further `imem_rd` for 20 cycles. With `NRISC_RESUME_EN`, a `resume` pulse gives `pc` + 1 and a fetch the next cycle.
- Reset asserted mid-WAIT → next cycle `pc` = 0, state FETCH, and a late `imem_ready` does not load `ir`.
